instruction_issue: RTL and testbench
====================================

Name: instruction_issue

Overview:
- Sequencer that feeds the instruction decoder. On `start` it reads 64-bit instructions from the on-chip instruction RAM, starting at `base_addr`.
- It presents each instruction on `instruction`, with `instr_enable` high for exactly one cycle.
- For fetch and CLP opcodes it waits for the matching completion pulse before issuing the next one.
- It stops on an END opcode, when the instruction count is exhausted, or on an error.

Parameters:
- ADDR_W, 10, instruction RAM address width.
- TIMEOUT_W, 16, width of the completion-wait watchdog counter.
- TIMEOUT, 16'hFFFF, maximum cycles spent in WAIT_DONE before an error is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  start pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first instruction address; latched on start.
- instr_count  in  ADDR_W  number of instructions to process; latched on start.
- rd_en  out  1  instruction RAM read strobe.
- rd_addr  out  ADDR_W  instruction RAM read address.
- rd_data  in  64  RAM data, valid the cycle after rd_en (fixed 1-cycle latency).
- instruction  out  64  instruction word to the decoder.
- instr_enable  out  1  one-cycle issue strobe to the decoder.
- feature_fetch_done  in  1  feature fetcher completion pulse.
- weight_fetch_done  in  1  weight fetcher completion pulse.
- clp_done  in  1  conv engine completion pulse.
- busy  out  1  high from the cycle after start is accepted until FINISH exits.
- done  out  1  one-cycle pulse in FINISH.
- error  out  1  sticky; cleared on the next accepted start.
- issue_count  out  ADDR_W  number of instructions issued since the last start.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, internal address/remaining/timer registers 0. Reset mid-operation aborts immediately; no partial strobe survives.
- Opcode is instruction[63:56]. Wait class is decided from the opcode:
  - 8'h01: no wait.
  - 8'h02 / 8'h04: wait on weight_fetch_done if bit[48]=1, else on feature_fetch_done.
  - 8'h81: wait on clp_done.
  - 8'hFF: END, never issued.
  - Any other opcode: illegal.
- States: IDLE, READ, DATA, ISSUE, WAIT_DONE, FINISH.
- IDLE:
  - start=1 latches base_addr into addr and instr_count into remaining.
  - Clears error and issue_count, sets busy, goes to READ. If instr_count==0 it goes to FINISH instead.
  - start outside IDLE is ignored.
- READ: rd_en=1 and rd_addr=addr for exactly this cycle → DATA.
- DATA: rd_data is valid and is captured into the holding register.
  - END opcode → FINISH, nothing issued.
  - Illegal opcode → error=1, → FINISH, nothing issued.
  - Otherwise → ISSUE.
- ISSUE:
  - instruction=held word and instr_enable=1 for exactly this cycle.
  - issue_count+1, addr+1, remaining-1, timer cleared.
  - Next state: WAIT_DONE if the opcode has a wait class. Otherwise READ if remaining (after decrement) is non-zero, else FINISH.
- WAIT_DONE:
  - Completion pulses are sampled from the first WAIT_DONE cycle; pulses arriving during ISSUE or earlier are ignored.
  - Only the selected done input counts; other done inputs are ignored.
  - On the selected done: → READ if remaining≠0, else FINISH.
  - Otherwise the timer increments. Timer reaching TIMEOUT sets error=1 and → FINISH.
- FINISH: done=1 for one cycle, busy=0 on exit → IDLE. Total from start to done with instr_count=0 is 2 cycles.
- Timing: minimum issue spacing is 3 cycles (READ, DATA, ISSUE) for no-wait opcodes.
- Output hold: instruction holds its last issued value between strobes. The decoder qualifies it with instr_enable only.
- Address wrap: addr increments modulo 2^ADDR_W; wrap is not an error.
- issue_count holds after FINISH until the next start.

Decomposition:
- Shared package tproc_isa_pkg: opcode constants (OP_CFG=8'h01, OP_FETCH=8'h02, OP_FETCH_W=8'h04, OP_CONV=8'h81, OP_END=8'hFF), the wait-class enum (NONE, FEAT, WGT, CLP), and a 64-bit instruction field-slice function shared with instruction_decode.
- One natural sub-module, instr_wait_class: a combinational opcode/reg_1 → wait-class plus illegal flag. The FSM stays in instruction_issue.

Test Plan:
- Three no-wait instructions:
  - Stimulus: base_addr=5, instr_count=3, RAM[5..7]=0x01... words.
  - Response: rd_addr 5,6,7 in order; instr_enable pulses exactly 3 cycles apart; done one cycle after the last ISSUE; issue_count=3, error=0.
- Fetch waits:
  - Stimulus: RAM[0]=0x0201_0000_0000_0000 (weight), RAM[1]=0x0200_... (feature), instr_count=2.
  - Response: no second read until weight_fetch_done pulses. A feature_fetch_done pulse during the first wait is ignored; the second instruction then waits on feature_fetch_done.
- END opcode:
  - Stimulus: RAM[2]=0xFF..., instr_count=10.
  - Response: 2 instructions issued, 0xFF word never appears with instr_enable, issue_count=2, done pulses, error=0.
- Illegal opcode and watchdog:
  - Stimulus A: RAM[0]=0x33... Response: no issue, error=1, done pulses.
  - Stimulus B: 0x81 instruction with clp_done held low and TIMEOUT=20. Response: error=1 after 20 WAIT_DONE cycles.
  - A subsequent start clears error.
- Edge cases:
  - instr_count=0: done 2 cycles after start, rd_en never asserted.
  - base_addr=2^ADDR_W-1 with instr_count=2: rd_addr goes max then 0.
  - start pulsed while busy: ignored, counts unchanged.
- Reset mid-wait:
  - Stimulus: assert rst=0 asynchronously during WAIT_DONE.
  - Response: all outputs 0 immediately, IDLE after release, a new start runs normally from the new base_addr.

Source files
------------

// File: rtl/tproc_isa_pkg.sv
// ISA constants, wait classes and instruction field layout shared by the
// instruction issue sequencer and the instruction decoder.
package tproc_isa_pkg;

    localparam logic [7:0] OP_CFG     = 8'h01;
    localparam logic [7:0] OP_FETCH   = 8'h02;
    localparam logic [7:0] OP_FETCH_W = 8'h04;
    localparam logic [7:0] OP_CONV    = 8'h81;
    localparam logic [7:0] OP_END     = 8'hFF;

    typedef enum logic [1:0] {
        WC_NONE = 2'd0,
        WC_FEAT = 2'd1,
        WC_WGT  = 2'd2,
        WC_CLP  = 2'd3
    } wait_class_e;

    // reg_1[0] is instruction bit 48: selects the weight fetcher for fetches.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  reg_1;
        logic [47:0] imm;
    } instr_t;

    function automatic instr_t instr_fields(input logic [63:0] word);
        return instr_t'(word);
    endfunction

endpackage

// File: rtl/instr_wait_class.sv
// Opcode decode: which completion pulse an instruction waits on, and whether
// the opcode is outside the ISA (END is legal but carries no wait class).
module instr_wait_class
    import tproc_isa_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic       reg_1,
    output logic [1:0] wait_class,
    output logic       illegal
);

    always_comb begin
        wait_class = WC_NONE;
        illegal    = 1'b0;
        case (opcode)
            OP_CFG:                wait_class = WC_NONE;
            OP_FETCH, OP_FETCH_W:  wait_class = reg_1 ? WC_WGT : WC_FEAT;
            OP_CONV:               wait_class = WC_CLP;
            OP_END:                wait_class = WC_NONE;
            default:               illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_issue.sv
// Sequencer that reads instructions from the instruction RAM and issues them to
// the decoder one at a time, stalling on fetch/conv completion pulses.
module instruction_issue
    import tproc_isa_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          TIMEOUT_W = 16,
    parameter int unsigned TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] instr_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [63:0]       rd_data,
    output logic [63:0]       instruction,
    output logic              instr_enable,
    input  logic              feature_fetch_done,
    input  logic              weight_fetch_done,
    input  logic              clp_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] issue_count,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_DATA      = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_e                state;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     remaining;
    logic [TIMEOUT_W-1:0]  timer;
    wait_class_e           wc_q;
    instr_t                rd_f;
    logic [1:0]            rd_wc;
    logic                  rd_illegal;
    logic                  sel_done;

    assign rd_f      = instr_fields(rd_data);
    assign state_dbg = state;

    instr_wait_class u_wait_class (
        .opcode     (rd_f.opcode),
        .reg_1      (rd_f.reg_1[0]),
        .wait_class (rd_wc),
        .illegal    (rd_illegal)
    );

    // Only the completion line chosen by the issued opcode can end a wait.
    always_comb begin
        sel_done = 1'b0;
        case (wc_q)
            WC_FEAT: sel_done = feature_fetch_done;
            WC_WGT:  sel_done = weight_fetch_done;
            WC_CLP:  sel_done = clp_done;
            default: sel_done = 1'b0;
        endcase
    end

    // Handshake: instruction is meaningful only in the cycle instr_enable is
    // high; done is a single-cycle pulse; completion inputs are single-cycle
    // pulses sampled only while waiting. There is no back-pressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            addr         <= '0;
            remaining    <= '0;
            timer        <= '0;
            wc_q         <= WC_NONE;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            instruction  <= '0;
            instr_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            issue_count  <= '0;
        end else begin
            rd_en        <= 1'b0;
            instr_enable <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr        <= base_addr;
                        remaining   <= instr_count;
                        timer       <= '0;
                        error       <= 1'b0;
                        issue_count <= '0;
                        busy        <= 1'b1;
                        if (instr_count == '0) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_addr <= base_addr;
                        end
                    end
                end
                S_READ: state <= S_DATA;
                S_DATA: begin
                    if (rd_f.opcode == OP_END) begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else if (rd_illegal) begin
                        error <= 1'b1;
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else begin
                        instruction  <= rd_f;
                        instr_enable <= 1'b1;
                        wc_q         <= wait_class_e'(rd_wc);
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    issue_count <= issue_count + 1'b1;
                    addr        <= addr + 1'b1;
                    remaining   <= remaining - 1'b1;
                    timer       <= '0;
                    if (wc_q != WC_NONE) begin
                        state <= S_WAIT_DONE;
                    end else if (remaining != ADDR_W'(1)) begin
                        state   <= S_READ;
                        rd_en   <= 1'b1;
                        rd_addr <= addr + 1'b1;
                    end else begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (sel_done) begin
                        if (remaining != '0) begin
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_addr <= addr;
                        end else begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        error <= 1'b1;
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_issue.sv
// Bench for instruction_issue: a per-run timeline model derived from the
// issue rules, checked against the DUT every cycle, plus directed pins.
module tb_instruction_issue;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 20;
    localparam int MAXC    = 400;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] instr_count = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [63:0]       rd_data;
    logic [63:0]       instruction;
    logic              instr_enable;
    logic              feature_fetch_done = 1'b0;
    logic              weight_fetch_done = 1'b0;
    logic              clp_done = 1'b0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] issue_count;
    logic [2:0]        state_dbg;

    instruction_issue #(.ADDR_W(ADDR_W), .TIMEOUT_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .instr_count(instr_count), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .instruction(instruction), .instr_enable(instr_enable),
        .feature_fetch_done(feature_fetch_done), .weight_fetch_done(weight_fetch_done),
        .clp_done(clp_done), .busy(busy), .done(done), .error(error),
        .issue_count(issue_count), .state_dbg(state_dbg)
    );

    // ---------------- clock / RAM ----------------
    always #5 clk = ~clk;

    logic [63:0] ram [1024];
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // ---------------- model storage ----------------
    logic              e_rd_en [MAXC];
    logic [ADDR_W-1:0] e_rd_addr [MAXC];
    logic              e_en [MAXC];
    logic [63:0]       e_instr [MAXC];
    logic              e_busy [MAXC], e_done [MAXC], e_err [MAXC];
    logic [ADDR_W-1:0] e_ic [MAXC];
    logic              d_feat [MAXC], d_wgt [MAXC], d_clp [MAXC];
    logic              ev_read [MAXC];
    logic [ADDR_W-1:0] ev_addr [MAXC];
    logic              ev_issue [MAXC];
    logic [63:0]       ev_word [MAXC];
    logic [63:0]       exp_q [$];

    int fin, err_at, n_issued;
    logic [ADDR_W-1:0] p_addr = '0, p_ic = '0;
    logic [63:0]       p_instr = '0;
    logic              p_err = 1'b0;

    int vectors = 0, miscompares = 0;
    bit chk_on = 1'b0;
    int cur_t = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cur_t, act, exp);
        end
    endtask

    task automatic set_line(input logic [7:0] op, input logic b48, input int c);
        if (op == 8'h81) d_clp[c] = 1'b1;
        else if (b48)    d_wgt[c] = 1'b1;
        else             d_feat[c] = 1'b1;
    endtask

    task automatic set_wrong(input logic [7:0] op, input logic b48, input int c);
        int k;
        k = $urandom_range(0, 1);
        if (op == 8'h81)  begin if (k != 0) d_wgt[c] = 1'b1; else d_feat[c] = 1'b1; end
        else if (b48)     begin if (k != 0) d_clp[c] = 1'b1; else d_feat[c] = 1'b1; end
        else              begin if (k != 0) d_clp[c] = 1'b1; else d_wgt[c]  = 1'b1; end
    endtask

    // Timeline: start in cycle 0; each instruction takes READ/DATA/ISSUE
    // cycles t, t+1, t+2; waits run from ISSUE+1 until the selected pulse.
    task automatic build_model(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count,
                               input bit never);
        int t, ti, d, rem;
        logic [ADDR_W-1:0] a;
        logic [63:0] w;
        logic [7:0] op;
        for (int i = 0; i < MAXC; i++) begin
            ev_read[i] = 1'b0; ev_addr[i] = '0; ev_issue[i] = 1'b0; ev_word[i] = '0;
            d_feat[i] = 1'b0; d_wgt[i] = 1'b0; d_clp[i] = 1'b0;
        end
        fin = -1; err_at = -1; n_issued = 0; t = 1; a = base; rem = int'(count);
        if (count == '0) fin = 1;
        while (fin < 0) begin
            ev_read[t] = 1'b1; ev_addr[t] = a; w = ram[a]; op = w[63:56];
            if (op == 8'hFF) begin
                fin = t + 2;
            end else if (!(op inside {8'h01, 8'h02, 8'h04, 8'h81})) begin
                fin = t + 2; err_at = t + 2;
            end else begin
                ti = t + 2;
                ev_issue[ti] = 1'b1; ev_word[ti] = w; exp_q.push_back(w);
                n_issued++; rem--; a = a + 1'b1;
                if (op == 8'h01) begin
                    t = ti + 1;
                end else begin
                    if ($urandom_range(0, 1) != 0) set_line(op, w[48], ti);
                    set_wrong(op, w[48], ti + 1);
                    if (never) begin
                        t = ti + TIMEOUT + 1; fin = t; err_at = t;
                    end else begin
                        d = $urandom_range(2, 6);
                        set_line(op, w[48], ti + d);
                        t = ti + d + 1;
                    end
                end
                if (fin < 0 && rem == 0) fin = t;
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            if (c == 1) begin p_ic = '0; p_err = 1'b0; end
            if (c >= 1 && ev_issue[c-1]) p_ic = p_ic + 1'b1;
            if (ev_read[c]) p_addr = ev_addr[c];
            if (ev_issue[c]) p_instr = ev_word[c];
            if (c == err_at) p_err = 1'b1;
            e_rd_en[c] = ev_read[c]; e_rd_addr[c] = p_addr;
            e_en[c] = ev_issue[c]; e_instr[c] = p_instr;
            e_busy[c] = (c >= 1 && c <= fin); e_done[c] = (c == fin);
            e_err[c] = p_err; e_ic[c] = p_ic;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("rd_en", 64'(rd_en), 64'(e_rd_en[cur_t]));
            if (rd_en === 1'b1) check("rd_addr", 64'(rd_addr), 64'(e_rd_addr[cur_t]));
            check("instr_enable", 64'(instr_enable), 64'(e_en[cur_t]));
            check("instruction", instruction, e_instr[cur_t]);
            check("busy", 64'(busy), 64'(e_busy[cur_t]));
            check("done", 64'(done), 64'(e_done[cur_t]));
            check("error", 64'(error), 64'(e_err[cur_t]));
            check("issue_count", 64'(issue_count), 64'(e_ic[cur_t]));
            if (instr_enable === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_issue", instruction, 64'hDEAD);
                else check("issued_word", instruction, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_case(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count,
                            input bit never);
        int junk;
        build_model(base, count, never);
        junk = $urandom_range(1, fin);
        for (int t = 0; t <= fin + 2; t++) begin
            @(posedge clk); #1;
            cur_t = t; chk_on = 1'b1;
            start       = (t == 0) || (t == junk);
            base_addr   = (t == 0) ? base  : ADDR_W'($urandom);
            instr_count = (t == 0) ? count : ADDR_W'($urandom);
            feature_fetch_done = d_feat[t];
            weight_fetch_done  = d_wgt[t];
            clp_done           = d_clp[t];
        end
        @(posedge clk); #1;
        chk_on = 1'b0; start = 1'b0;
        feature_fetch_done = 1'b0; weight_fetch_done = 1'b0; clp_done = 1'b0;
        check("issue_queue_left", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic fill_random(input logic [ADDR_W-1:0] base, input int n);
        logic [ADDR_W-1:0] a;
        int r;
        logic [7:0] op;
        a = base;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      op = 8'h01;
            else if (r < 55) op = 8'h02;
            else if (r < 70) op = 8'h04;
            else if (r < 88) op = 8'h81;
            else if (r < 94) op = 8'hFF;
            else             op = 8'h10 + 8'($urandom_range(0, 15));
            ram[a] = {op, 24'($urandom), 32'($urandom)};
            a = a + 1'b1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        #2;
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_instr_enable", 64'(instr_enable), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_issue_count", 64'(issue_count), 64'(0));
        check("rst_instruction", instruction, 64'(0));
        @(negedge clk); rst = 1'b1;

        // three no-wait instructions, with a stray start while busy
        ram[5] = 64'h0100_0000_0000_0005;
        ram[6] = 64'h0100_0000_0000_0006;
        ram[7] = 64'h0100_0000_0000_0007;
        run_case(10'd5, 10'd3, 1'b0);
        check("pin_t1_finish_cycle", 64'(fin), 64'(10));
        check("t1_issue_count", 64'(issue_count), 64'(3));
        check("t1_error", 64'(error), 64'(0));

        // weight fetch then feature fetch
        ram[0] = 64'h0201_0000_0000_0000;
        ram[1] = 64'h0200_0000_0000_0001;
        run_case(10'd0, 10'd2, 1'b0);
        check("pin_t2_issued", 64'(n_issued), 64'(2));
        check("t2_issue_count", 64'(issue_count), 64'(2));

        // END opcode stops early
        ram[0] = 64'h0100_0000_0000_00A0;
        ram[1] = 64'h0100_0000_0000_00A1;
        ram[2] = 64'hFF00_0000_0000_0000;
        run_case(10'd0, 10'd10, 1'b0);
        check("pin_t3_issued", 64'(n_issued), 64'(2));
        check("t3_issue_count", 64'(issue_count), 64'(2));
        check("t3_error", 64'(error), 64'(0));

        // illegal opcode
        ram[0] = 64'h3300_0000_0000_0000;
        run_case(10'd0, 10'd1, 1'b0);
        check("pin_t4a_finish_cycle", 64'(fin), 64'(3));
        check("t4a_error", 64'(error), 64'(1));
        check("t4a_issue_count", 64'(issue_count), 64'(0));

        // watchdog on a conv that never completes
        ram[0] = 64'h8100_0000_0000_0042;
        run_case(10'd0, 10'd1, 1'b0 | 1'b1);
        check("pin_t4b_finish_cycle", 64'(fin), 64'(24));
        check("t4b_error", 64'(error), 64'(1));

        // zero count: error from the watchdog run is cleared by this start
        run_case(10'd0, 10'd0, 1'b0);
        check("pin_t5_finish_cycle", 64'(fin), 64'(1));
        check("t5_error", 64'(error), 64'(0));

        // address wrap
        ram[1023] = 64'h0100_0000_0000_03FF;
        ram[0]    = 64'h0100_0000_0000_0000;
        run_case(10'd1023, 10'd2, 1'b0);
        check("pin_wrap_first", 64'(ev_addr[1]), 64'(1023));
        check("pin_wrap_second", 64'(ev_addr[4]), 64'(0));

        // reset during WAIT_DONE
        ram[0] = 64'h8100_0000_0000_0011;
        ram[1] = 64'h0100_0000_0000_0012;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd0; instr_count = 10'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("pre_rst_busy", 64'(busy), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("midrst_rd_en", 64'(rd_en), 64'(0));
        check("midrst_rd_addr", 64'(rd_addr), 64'(0));
        check("midrst_instruction", instruction, 64'(0));
        check("midrst_instr_enable", 64'(instr_enable), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_error", 64'(error), 64'(0));
        check("midrst_issue_count", 64'(issue_count), 64'(0));
        check("midrst_state", 64'(state_dbg), 64'(0));
        #10 rst = 1'b1;
        p_addr = '0; p_ic = '0; p_instr = '0; p_err = 1'b0;
        ram[7] = 64'h0400_0000_0000_0077;
        run_case(10'd7, 10'd1, 1'b0);
        check("post_rst_issue_count", 64'(issue_count), 64'(1));

        // randomized programs
        for (int n = 0; n < 25; n++) begin
            logic [ADDR_W-1:0] b;
            logic [ADDR_W-1:0] c;
            b = ADDR_W'($urandom);
            c = ADDR_W'($urandom_range(0, 6));
            fill_random(b, int'(c) + 1);
            run_case(b, c, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
